// File: rtl/brcmp_pkg.sv
// Shared types and helpers for the iterative RV32I branch comparator.
package brcmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    // 010/011 are the only reserved encodings in the branch major opcode
    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

    // signedness is chosen by brun, so BLT/BLTU and BGE/BGEU share a decision
    function automatic logic f3_taken(input logic [2:0] f3, input logic lt, input logic eq);
        logic t;
        case (f3)
            BEQ:        t = eq;
            BNE:        t = !eq;
            BLT, BLTU:  t = lt;
            BGE, BGEU:  t = !lt;
            default:    t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/brcmp_slice.sv
// Combinational unsigned compare of one CHUNK-bit slice; inv_msb flips the
// top bit of both operands so the sign slice orders as two's complement.
module brcmp_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             inv_msb,
    output logic             lt,
    output logic             eq
);

    logic [CHUNK-1:0] a_m;
    logic [CHUNK-1:0] b_m;

    // optional sign-bit flip, then plain magnitude compare
    always_comb begin
        a_m            = a;
        b_m            = b;
        a_m[CHUNK-1]   = a[CHUNK-1] ^ inv_msb;
        b_m[CHUNK-1]   = b[CHUNK-1] ^ inv_msb;
        lt             = (a_m < b_m);
        eq             = (a_m == b_m);
    end

endmodule

// File: rtl/brcmp_iter.sv
// Iterative branch comparator: walks the operands one slice per cycle from the
// MSB slice down and stops at the first differing slice.
//
// state   | meaning
// IDLE    | ready for a request
// BUSY    | comparing slice idx_q
// DONE    | result held until out_ready
module brcmp_iter
    import brcmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             brun,
    input  logic [2:0]       funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             brlt,
    output logic             breq,
    output logic             taken,
    output logic             illegal
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("brcmp_iter: WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             brun_q, brun_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             brlt_q, brlt_d;
    logic             breq_q, breq_d;

    logic [CHUNK-1:0] sl_a;
    logic [CHUNK-1:0] sl_b;
    logic             sl_inv;
    logic             sl_lt;
    logic             sl_eq;

    // pick the slice under examination; only the top slice gets the sign flip
    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IW'(i)) begin
                sl_a = a_q[i*CHUNK +: CHUNK];
                sl_b = b_q[i*CHUNK +: CHUNK];
            end
        end
        sl_inv = (idx_q == IDX_TOP) && !brun_q;
    end

    brcmp_slice #(.CHUNK(CHUNK)) u_slice (
        .a       (sl_a),
        .b       (sl_b),
        .inv_msb (sl_inv),
        .lt      (sl_lt),
        .eq      (sl_eq)
    );

    // next-state and output decode
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        brun_d    = brun_q;
        funct3_d  = funct3_q;
        brlt_d    = brlt_q;
        breq_d    = breq_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    brun_d   = brun;
                    funct3_d = funct3;
                    idx_d    = IDX_TOP;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!sl_eq) begin
                    brlt_d  = sl_lt;
                    breq_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (idx_q == '0) begin
                    brlt_d  = 1'b0;
                    breq_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q - IW'(1);
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        brlt    = out_valid & brlt_q;
        breq    = out_valid & breq_q;
        taken   = out_valid & f3_taken(funct3_q, brlt_q, breq_q);
        illegal = out_valid & f3_illegal(funct3_q);
    end

    // state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            brun_q   <= 1'b0;
            funct3_q <= 3'b000;
            brlt_q   <= 1'b0;
            breq_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            brun_q   <= brun_d;
            funct3_q <= funct3_d;
            brlt_q   <= brlt_d;
            breq_q   <= breq_d;
        end
    end

endmodule

// File: tb/tb_brcmp_iter.sv
// Directed plus random bench for brcmp_iter (WIDTH=32, CHUNK=8).
module tb_brcmp_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        brun = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        brlt;
    logic        breq;
    logic        taken;
    logic        illegal;

    int checks = 0;
    int failures = 0;

    brcmp_iter #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .brun      (brun),
        .funct3    (funct3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .brlt      (brlt),
        .breq      (breq),
        .taken     (taken),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // independent golden model of the comparator
    task automatic gold(input logic [31:0] ga, input logic [31:0] gb, input logic gu,
                        input logic [2:0] gf, output int lat, output logic lt,
                        output logic eq, output logic tk, output logic il);
        logic [31:0] x;
        logic found;
        lt = gu ? (ga < gb) : ($signed(ga) < $signed(gb));
        eq = (ga == gb);
        x = ga ^ gb;
        lat = 4;
        found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!found && x[i*8 +: 8] != 8'h00) begin
                lat = 4 - i;
                found = 1'b1;
            end
        end
        il = (gf == 3'b010) || (gf == 3'b011);
        case (gf)
            3'b000:          tk = eq;
            3'b001:          tk = !eq;
            3'b100, 3'b110:  tk = lt;
            3'b101, 3'b111:  tk = !lt;
            default:         tk = 1'b0;
        endcase
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic vu, input logic [2:0] vf, input int e_lat,
                           input logic e_lt, input logic e_eq, input logic e_tk, input logic e_il);
        int lat;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        a = va; b = vb; brun = vu; funct3 = vf; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_result(lat);
        chk({tag, ".latency"}, 32'(lat), 32'(e_lat));
        chk({tag, ".brlt"},    32'(brlt), 32'(e_lt));
        chk({tag, ".breq"},    32'(breq), 32'(e_eq));
        chk({tag, ".taken"},   32'(taken), 32'(e_tk));
        chk({tag, ".illegal"}, 32'(illegal), 32'(e_il));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".released"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int          g_lat;
        logic        g_lt, g_eq, g_tk, g_il;
        logic [31:0] ra, rb, rt;
        logic        ru;
        logic [2:0]  rf;
        int          sel;

        // reset
        rst_n = 1'b0;
        step(); step(); step();
        rst_n = 1'b1;
        step();
        chk("rst.in_ready",  32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.brlt",      32'(brlt), 32'd0);
        chk("rst.breq",      32'(breq), 32'd0);
        chk("rst.taken",     32'(taken), 32'd0);
        chk("rst.illegal",   32'(illegal), 32'd0);

        // hand-computed directed vectors
        run_vec("blt_sign",   32'h80000000, 32'h00000001, 1'b0, 3'b100, 1, 1'b1, 1'b0, 1'b1, 1'b0);
        run_vec("bltu_sign",  32'h80000000, 32'h00000001, 1'b1, 3'b100, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("beq_equal",  32'h12345678, 32'h12345678, 1'b0, 3'b000, 4, 1'b0, 1'b1, 1'b1, 1'b0);
        run_vec("bgeu_carry", 32'h000000FF, 32'h00000100, 1'b1, 3'b111, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        run_vec("ill_010",    32'h00000005, 32'h00000007, 1'b0, 3'b010, 4, 1'b1, 1'b0, 1'b0, 1'b1);
        run_vec("ill_011",    32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 3'b011, 4, 1'b0, 1'b1, 1'b0, 1'b1);
        run_vec("bge_neg",    32'hFFFFFFFF, 32'h00000000, 1'b0, 3'b101, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_vec("bne_low",    32'h00000001, 32'h00000002, 1'b1, 3'b001, 4, 1'b1, 1'b0, 1'b1, 1'b0);
        run_vec("bgeu_big",   32'hFFFFFFFF, 32'h00000000, 1'b1, 3'b111, 1, 1'b0, 1'b0, 1'b1, 1'b0);

        // hold in DONE with out_ready low while a new request waits
        a = 32'h00000010; b = 32'h00000020; brun = 1'b1; funct3 = 3'b110; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_result(g_lat);
        chk("hold.latency", 32'(g_lat), 32'd4);
        a = 32'hFFFFFFFF; b = 32'h00000000; brun = 1'b0; funct3 = 3'b000; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("hold.out_valid", 32'(out_valid), 32'd1);
            chk("hold.in_ready",  32'(in_ready), 32'd0);
            chk("hold.brlt",      32'(brlt), 32'd1);
            chk("hold.breq",      32'(breq), 32'd0);
            chk("hold.taken",     32'(taken), 32'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hold.idle_ready", 32'(in_ready), 32'd1);
        chk("hold.idle_valid", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        chk("hold.accepted", 32'(in_ready), 32'd0);
        wait_result(g_lat);
        chk("hold.new_lat",   32'(g_lat), 32'd1);
        chk("hold.new_brlt",  32'(brlt), 32'd1);
        chk("hold.new_taken", 32'(taken), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // reset in the middle of BUSY discards the result
        a = 32'hCAFEF00D; b = 32'hCAFEF00D; brun = 1'b0; funct3 = 3'b000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst.in_ready",  32'(in_ready), 32'd1);
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        for (int c = 0; c < 8; c++) begin
            step();
            chk("midrst.no_stale", 32'(out_valid), 32'd0);
        end
        run_vec("post_rst", 32'h00000003, 32'h00000003, 1'b1, 3'b001, 4, 1'b0, 1'b1, 1'b0, 1'b0);

        // random requests against the golden model
        for (int n = 0; n < 1000; n++) begin
            ra  = $urandom;
            ru  = 1'($urandom_range(0, 1));
            rf  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 3);
            rt  = $urandom;
            case (sel)
                0:       rb = rt;
                1:       rb = ra;
                2:       rb = ra ^ (32'd1 << $urandom_range(0, 31));
                default: rb = {ra[31:16], rt[15:0]};
            endcase
            gold(ra, rb, ru, rf, g_lat, g_lt, g_eq, g_tk, g_il);
            run_vec("rand", ra, rb, ru, rf, g_lat, g_lt, g_eq, g_tk, g_il);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/brcmp_iter.md
BRCMP_ITER -- requirements
Module: brcmp_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, meaning bits compared per cycle; WIDTH % CHUNK == 0 required, elaboration error otherwise.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port a  input  WIDTH  operand rs1.
REQ-008 SHALL have port b  input  WIDTH  operand rs2.
REQ-009 SHALL have port brun  input  1  1 = unsigned compare, 0 = signed.
REQ-010 SHALL have port funct3  input  3  RV32I branch funct3.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port brlt  output  1  a < b under latched brun.
REQ-014 SHALL have port breq  output  1  a == b.
REQ-015 SHALL have port taken  output  1  branch decision for latched funct3.
REQ-016 SHALL have port illegal  output  1  latched funct3 is 010 or 011.

Function
REQ-017 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE; NCHUNK = WIDTH/CHUNK.
REQ-018 IDLE: in_ready=1, out_valid=0; on in_valid at edge, latch a, b, brun, funct3, set chunk index = NCHUNK-1, go BUSY.
REQ-019 BUSY: in_ready=0; each edge compares one CHUNK-bit slice at the index, MSB slice first.
REQ-020 On MSB slice with brun=0, the top bit of each operand SHALL be inverted before unsigned slice compare (two's-complement ordering).
REQ-021 Slices differ: brlt = (slice_a < slice_b), breq=0, go DONE (early termination).
REQ-022 Slices equal and index==0: brlt=0, breq=1, go DONE; else index decrements, stay BUSY.
REQ-023 Latency: out_valid asserts k edges after accept edge, k = slices examined, 1 <= k <= NCHUNK.
REQ-024 DONE: out_valid=1; brlt, breq, taken, illegal held stable until out_ready=1 at an edge, then IDLE.
REQ-025 No accept in DONE even if out_ready=1 same cycle; next accept earliest one cycle later (in IDLE).
REQ-026 taken: 000 breq, 001 !breq, 100/110 brlt, 101/111 !brlt; 010/011 taken=0, illegal=1.
REQ-027 brun is used as given; funct3 does not override signedness.
REQ-028 in_valid, a, b ignored outside IDLE; outputs other than in_ready are 0 when out_valid=0.

Reset
REQ-029 rst_n=0 at an edge SHALL force IDLE, index=0, all outputs 0 except in_ready=1 from next cycle, regardless of state.
REQ-030 An in-flight or unconsumed result SHALL be discarded by reset; no out_valid for it afterwards.

Structure
REQ-031 Package brcmp_pkg SHALL hold FSM state enum and funct3 localparams (BEQ, BNE, BLT, BGE, BLTU, BGEU).
REQ-032 One sub-module brcmp_slice SHALL be instantiated: combinational CHUNK-bit compare with invert-MSB input, outputs lt, eq.

Verification (WIDTH=32, CHUNK=8)
REQ-033 a=0x80000000, b=0x00000001, brun=0, funct3=100 -> out_valid 1 edge after accept, brlt=1, taken=1; repeat brun=1 -> brlt=0, taken=0.
REQ-034 a=b=0x12345678, funct3=000 -> breq=1, brlt=0, taken=1, out_valid 4 edges after accept.
REQ-035 a=0x000000FF, b=0x00000100, brun=1, funct3=111 -> brlt=1, taken=0, out_valid 3 edges after accept.
REQ-036 out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE, next request accepted following cycle.
REQ-037 rst_n=0 for one edge during BUSY -> next cycle in_ready=1, out_valid=0, no stale result ever appears.
REQ-038 funct3=010, any a,b -> illegal=1, taken=0; plus 1000 random a, b, brun, funct3 checked against golden compare.
